// File: rtl/tx_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_line_buffer
// Brief    : Byte FIFO between uart_rx and uart_tx with optional CR->CR LF
//            expansion and overflow drop counting.
// Revision : 1.0
// ============================================================================
module tx_line_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter bit CRLF_EN    = 1'b1,
    parameter int HOLDOFF    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic [7:0]            drop_cnt,
    output logic                  overflow
);

    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [7:0]        c_HOLD  = 8'(HOLDOFF);
    localparam logic [7:0]        c_CR    = 8'h0D;
    localparam logic [7:0]        c_LF    = 8'h0A;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [7:0]              r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic [DEPTH_LOG2:0]     w_count_next;
    logic                    r_empty;
    logic                    r_full;
    logic                    r_tx_start;
    logic [7:0]              r_tx_data;
    logic                    r_lf_pending;
    logic [7:0]              r_drop_cnt;
    logic                    r_overflow;
    logic [7:0]              r_hold;

    logic                    w_push;
    logic                    w_drop;
    logic                    w_pop;
    logic                    w_send_lf;
    logic [7:0]              w_head;

    assign w_head = r_mem[r_rd_ptr];

    // The pending LF outranks queued data so a CR LF pair is never split.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_send_lf    = 1'b0;
        w_push       = in_valid && !r_full;
        w_drop       = in_valid && r_full;
        case (r_state)
            S_IDLE: begin
                if (tx_ready) begin
                    if (r_lf_pending) begin
                        w_send_lf    = 1'b1;
                        w_state_next = S_WAIT;
                    end else if (!r_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!tx_ready || (r_hold == c_HOLD)) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
        w_count_next = r_count + {{DEPTH_LOG2{1'b0}}, w_push}
                               - {{DEPTH_LOG2{1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_lf_pending <= 1'b0;
            r_drop_cnt   <= 8'h00;
            r_overflow   <= 1'b0;
            r_hold       <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= w_pop || w_send_lf;
            if (w_send_lf) begin
                r_tx_data    <= c_LF;
                r_lf_pending <= 1'b0;
            end else if (w_pop) begin
                r_tx_data    <= w_head;
                r_lf_pending <= CRLF_EN && (w_head == c_CR);
                r_rd_ptr     <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            // Hold counter is zero on WAIT entry and saturates at HOLDOFF.
            if (r_state == S_IDLE) begin
                r_hold <= 8'h00;
            end else if (r_hold != c_HOLD) begin
                r_hold <= r_hold + 8'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == c_FULL);
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign count    = r_count;
    assign empty    = r_empty;
    assign full     = r_full;
    assign drop_cnt = r_drop_cnt;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tx_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_line_buffer
// Brief    : Self-checking bench for tx_line_buffer (CRLF on and off).
// Revision : 1.0
// ============================================================================
module tb_tx_line_buffer;

    localparam int c_DEPTH = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       empty, full, overflow;
    logic [7:0] drop_cnt;

    logic       tx_start2;
    logic [7:0] tx_data2;
    logic [4:0] count2;
    logic       empty2, full2, overflow2;
    logic [7:0] drop_cnt2;

    tx_line_buffer #(.DEPTH_LOG2(4), .CRLF_EN(1'b1), .HOLDOFF(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .count(count), .empty(empty), .full(full),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    // Second instance: no CR expansion, transmitter tied ready.
    tx_line_buffer #(.DEPTH_LOG2(4), .CRLF_EN(1'b0), .HOLDOFF(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .tx_ready(1'b1), .tx_start(tx_start2), .tx_data(tx_data2),
        .count(count2), .empty(empty2), .full(full2),
        .drop_cnt(drop_cnt2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    logic       s_rst   = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic [7:0] qm[$];
    logic [7:0] got[$];
    logic [7:0] got2[$];
    logic       lf_owed    = 1'b0;
    int         m_drop     = 0;
    logic       m_ovf      = 1'b0;
    logic       prev_start = 1'b0;
    logic       chk_en     = 1'b0;
    logic       saw_full   = 1'b0;
    logic       tx_force_low = 1'b0;
    int         busy   = 0;
    int         tx_cyc = 3;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        s_rst   <= rst;
        s_valid <= in_valid;
        s_data  <= in_data;
    end

    // Transmitter model plus queue-based reference of the buffer.
    always @(negedge clk) begin
        logic [7:0] e;
        logic       was_full;
        if (tx_start2) got2.push_back(tx_data2);
        if (tx_start) busy = tx_cyc;
        else if (busy > 0) busy--;
        tx_ready = !tx_force_low && (busy == 0);
        if (s_rst) begin
            qm.delete();
            lf_owed    = 1'b0;
            m_drop     = 0;
            m_ovf      = 1'b0;
            prev_start = 1'b0;
        end else if (chk_en) begin
            was_full = (qm.size() == c_DEPTH);
            if (tx_start) begin
                chk("back_to_back_start", int'(prev_start), 0);
                if (lf_owed) begin
                    lf_owed = 1'b0;
                    chk("tx_data_lf", int'(tx_data), 8'h0A);
                end else if (qm.size() == 0) begin
                    chk("tx_start_no_data", int'(tx_start), 0);
                end else begin
                    e = qm.pop_front();
                    lf_owed = (e == 8'h0D);
                    chk("tx_data", int'(tx_data), int'(e));
                end
                got.push_back(tx_data);
            end
            if (s_valid) begin
                if (was_full) begin
                    m_drop++;
                    m_ovf = 1'b1;
                end else begin
                    qm.push_back(s_data);
                end
            end
            if (full) saw_full = 1'b1;
            chk("count", int'(count), qm.size());
            chk("empty", int'(empty), int'(qm.size() == 0));
            chk("full", int'(full), int'(qm.size() == c_DEPTH));
            chk("drop_cnt", int'(drop_cnt), m_drop % 256);
            chk("overflow", int'(overflow), int'(m_ovf));
            prev_start = tx_start;
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #2;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_got(input int n, input int bound, input string nm);
        int k = 0;
        while (got.size() < n && k < bound) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk({nm, "_timeout"}, int'(got.size() >= n), 1);
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, "_tx_start"}, int'(tx_start), 0);
        chk({nm, "_tx_data"}, int'(tx_data), 0);
        chk({nm, "_count"}, int'(count), 0);
        chk({nm, "_empty"}, int'(empty), 1);
        chk({nm, "_full"}, int'(full), 0);
        chk({nm, "_drop_cnt"}, int'(drop_cnt), 0);
        chk({nm, "_overflow"}, int'(overflow), 0);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       exp_lf;
    } vec_t;

    initial begin
        vec_t vt[6];
        vt[0] = '{8'h55, 1'b0};
        vt[1] = '{8'h0D, 1'b1};
        vt[2] = '{8'h0A, 1'b0};
        vt[3] = '{8'hFF, 1'b0};
        vt[4] = '{8'h00, 1'b0};
        vt[5] = '{8'h8D, 1'b0};

        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk_reset_values("reset");

        // Single byte: start exactly two cycles after the strobe cycle.
        got.delete();
        drive(1'b1, 8'h41);
        drive(1'b0, 8'h00);
        @(negedge clk);
        chk("lat_c1_start", int'(tx_start), 0);
        @(negedge clk);
        chk("lat_c2_start", int'(tx_start), 1);
        chk("lat_c2_data", int'(tx_data), 8'h41);
        idle(12);
        chk("single_count", int'(count), 0);
        chk("single_drop", int'(drop_cnt), 0);
        chk("single_n", got.size(), 1);

        // Table: one byte at a time through both instances.
        tx_cyc = 5;
        for (int i = 0; i < 6; i++) begin
            got.delete();
            got2.delete();
            drive(1'b1, vt[i].din);
            drive(1'b0, 8'h00);
            idle(25);
            chk("vec_n", got.size(), 1 + int'(vt[i].exp_lf));
            if (got.size() > 0) chk("vec_b0", int'(got[0]), int'(vt[i].din));
            if (vt[i].exp_lf && got.size() > 1) chk("vec_lf", int'(got[1]), 8'h0A);
            chk("vec2_n", got2.size(), 1);
            if (got2.size() > 0) chk("vec2_b0", int'(got2[0]), int'(vt[i].din));
        end

        // CR followed immediately by another byte.
        got.delete();
        got2.delete();
        drive(1'b1, 8'h0D);
        drive(1'b1, 8'h61);
        drive(1'b0, 8'h00);
        idle(40);
        chk("crlf_n", got.size(), 3);
        if (got.size() == 3) begin
            chk("crlf_0", int'(got[0]), 8'h0D);
            chk("crlf_1", int'(got[1]), 8'h0A);
            chk("crlf_2", int'(got[2]), 8'h61);
        end
        chk("nocrlf_n", got2.size(), 2);
        if (got2.size() == 2) begin
            chk("nocrlf_0", int'(got2[0]), 8'h0D);
            chk("nocrlf_1", int'(got2[1]), 8'h61);
        end
        chk("dut2_count", int'(count2), 0);
        chk("dut2_empty", int'(empty2), 1);
        chk("dut2_full", int'(full2), 0);
        chk("dut2_drop", int'(drop_cnt2), 0);
        chk("dut2_ovf", int'(overflow2), 0);

        // Burst against a slow transmitter.
        do_reset();
        tx_cyc   = 100;
        saw_full = 1'b0;
        got.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h30 + 8'(i));
            idle(2);
        end
        wait_got(16, 3000, "burst");
        for (int i = 0; i < 16 && i < got.size(); i++) chk("burst_order", int'(got[i]), 8'h30 + i);
        chk("burst_full_seen", int'(saw_full), 0);
        chk("burst_drop", int'(drop_cnt), 0);

        // Overflow with transmitter held busy.
        do_reset();
        tx_force_low = 1'b1;
        got.delete();
        for (int i = 0; i < 20; i++) drive(1'b1, 8'h80 + 8'(i));
        drive(1'b0, 8'h00);
        @(negedge clk);
        chk("ovf_full", int'(full), 1);
        chk("ovf_count", int'(count), 16);
        chk("ovf_drop", int'(drop_cnt), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_no_tx", got.size(), 0);
        tx_force_low = 1'b0;
        tx_cyc = 3;
        wait_got(16, 800, "ovf_drain");
        idle(20);
        chk("ovf_drain_n", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_order", int'(got[i]), 8'h80 + i);

        // Random pushes and pops across several pointer wraps.
        do_reset();
        got.delete();
        for (int i = 0; i < 70; i++) begin
            idle($urandom_range(0, 10));
            tx_cyc = $urandom_range(1, 12);
            drive(1'b1, 8'($urandom_range(0, 255)));
        end
        drive(1'b0, 8'h00);
        begin
            int k = 0;
            while ((qm.size() != 0 || lf_owed) && k < 3000) begin
                @(posedge clk);
                k++;
            end
        end
        idle(30);
        chk("rand_drained", qm.size(), 0);
        chk("rand_count", int'(count), 0);

        // Reset while an LF is pending and bytes are queued.
        do_reset();
        tx_cyc = 30;
        idle(40);
        got.delete();
        drive(1'b1, 8'h0D);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h03);
        drive(1'b1, 8'h04);
        drive(1'b0, 8'h00);
        idle(8);
        chk("mid_count", int'(count), 4);
        chk("mid_sent_n", got.size(), 1);
        if (got.size() > 0) chk("mid_sent_cr", int'(got[0]), 8'h0D);
        do_reset();
        @(negedge clk);
        chk_reset_values("mid_reset");
        got.delete();
        idle(60);
        chk("mid_no_lf", got.size(), 0);
        tx_cyc = 3;
        drive(1'b1, 8'h42);
        drive(1'b0, 8'h00);
        idle(20);
        chk("post_reset_n", got.size(), 1);
        if (got.size() > 0) chk("post_reset_b", int'(got[0]), 8'h42);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tx_line_buffer.md
Name: tx_line_buffer

Overview:
- Byte FIFO between the UART receive path (rcv pulse + data byte) and uart_tx (start/ready handshake).
- Replaces the single-byte holding register in the echo path, so back-to-back received bytes at 115200 baud are not lost while the transmitter is busy.
- Optionally expands CR (0x0D) into CR LF on output.
- Counts bytes dropped on overflow; this count drives the loss LED.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 bytes (legal range 1..8).
- CRLF_EN, 1, 1 = emit 0x0A after every transmitted 0x0D; 0 = pass bytes through unchanged.
- HOLDOFF, 4, max cycles to wait for tx_ready to fall after a tx_start pulse (legal range 1..255).

Ports:
- clk  in  1  system clock, 2.08 MHz internal oscillator
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  one-cycle strobe: in_data is valid (uart_rx rcv)
- in_data  in  8  received byte, already transformed upstream if required
- tx_ready  in  1  uart_tx idle/ready level
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to transmit; held stable from tx_start until the next tx_start
- count  out  DEPTH_LOG2+1  number of bytes currently stored
- empty  out  1  count == 0
- full  out  1  count == 2^DEPTH_LOG2
- drop_cnt  out  8  bytes discarded due to full FIFO; wraps modulo 256
- overflow  out  1  sticky; set on first drop, cleared only by rst

Behaviour:
- Reset (rst high at a clk edge):
  - tx_start=0, tx_data=0x00, count=0, empty=1, full=0, drop_cnt=0, overflow=0.
  - Read/write pointers reset to 0; FSM goes to IDLE; pending-LF flag cleared.
- Reset mid-transmit:
  - Aborts FIFO contents and any pending LF.
  - A byte already handed to uart_tx is that module's concern.
- Write rules:
  - in_valid=1 and full=0 (value at start of cycle): store in_data at wr_ptr, increment wr_ptr (wraps at 2^DEPTH_LOG2), count+1.
  - in_valid=1 and full=1: byte discarded, drop_cnt+1 (8-bit wrap), overflow=1. FIFO contents unchanged.
- Simultaneous push and pop in the same cycle (count neither full nor empty at cycle start): both occur; count unchanged.
- No push-to-pop bypass:
  - A byte written while the FIFO is empty is visible to the FSM the next cycle.
  - in_valid in cycle c -> earliest tx_start high in cycle c+2.
- FSM states:
  - IDLE:
    - If lf_pending and tx_ready: tx_data<=0x0A, tx_start<=1, lf_pending<=0, go to WAIT.
    - Else if !empty and tx_ready: tx_data<=mem[rd_ptr], tx_start<=1, pop (rd_ptr+1, count-1), lf_pending<=(CRLF_EN and byte==0x0D), go to WAIT.
    - LF has priority over FIFO data, so CR LF is never split by another byte.
  - WAIT:
    - tx_start<=0; a hold counter is loaded to 0 on entry.
    - Stay until tx_ready is seen low or the counter reaches HOLDOFF, then go to IDLE.
    - Guarantees no second start before uart_tx has accepted the first.
- tx_start is registered and is never high in two consecutive cycles.
- The LF is generated internally, never stored in the FIFO, and never dropped.
- full/empty/count are registered and consistent with each other every cycle.
- Wrap-around:
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - count is DEPTH_LOG2+1 bits, so full and empty are distinguishable.
- tx_ready permanently high (e.g. tied off): WAIT exits after HOLDOFF cycles and output proceeds.

Test Plan:
- Single byte: reset, in_valid with 0x41, bench tx model with ready high -> tx_start pulse in cycle c+2 with tx_data=0x41; count returns to 0; drop_cnt=0.
- Burst: 16 strobes of 0x30..0x3F spaced 3 cycles apart, tx model 100 cycles/byte, DEPTH_LOG2=4 -> all 16 bytes transmitted in order; full never asserted while drops occur; drop_cnt=0.
- Overflow: hold tx_ready low, push 20 bytes -> full=1 after 16; drop_cnt=4; overflow=1. Release tx_ready -> exactly the first 16 bytes sent in order.
- CRLF: push 0x0D, 0x61 with CRLF_EN=1 -> output sequence 0x0D, 0x0A, 0x61. With CRLF_EN=0 -> 0x0D, 0x61.
- Wrap and concurrency: push and pop simultaneously across 3 full pointer wraps with random gaps -> output equals input stream; count matches the reference model every cycle.
- Reset mid-operation: 5 bytes queued, last sent is 0x0D with LF pending, assert rst one cycle -> all outputs at reset values; no 0x0A emitted. A subsequent push of 0x42 is transmitted normally.
